// File: rtl/mem_burst_writer.sv
// Round-robin burst writer: serialises NUM_CH valid/ready result streams onto one memory write port.
// Latency: a transfer in cycle N gives a registered write in cycle N+1; one word per clock.
// Backpressure: data_ready is a combinational one-hot grant; finished or idle channels are never granted.
module mem_burst_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MEM_SIZE     = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int NUM_CH       = 2,
    parameter int SATURATE     = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_writing,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_base,
    input  logic [ADDR_WIDTH:0]            burst_len,
    input  logic [NUM_CH*RESULT_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]              data_valid,
    output logic [NUM_CH-1:0]              data_ready,
    output logic                           write_en,
    output logic [ADDR_WIDTH-1:0]          write_address,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [CH_W-1:0]                write_ch,
    output logic                           busy,
    output logic                           done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [ADDR_WIDTH:0] MEM_SZ  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(NUM_CH - 1);

    logic [1:0]                   state_q, state_d;
    logic [NUM_CH*ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]          len_q, len_d;
    logic [ADDR_WIDTH:0]          cnt_q [NUM_CH];
    logic [ADDR_WIDTH:0]          cnt_d [NUM_CH];
    logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                         we_q, we_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        dat_q, dat_d;
    logic [CH_W-1:0]              ch_q, ch_d;

    logic [NUM_CH-1:0]            eligible;
    logic [NUM_CH-1:0]            gnt;
    logic                         gnt_vld;
    logic [CH_W-1:0]              gnt_idx;
    logic [CH_W-1:0]              idx_c;
    int                           idx;
    logic [RESULT_WIDTH-1:0]      res_sel;
    logic [ADDR_WIDTH:0]          addr_sum;
    logic [ADDR_WIDTH-1:0]        addr_wrap;
    logic [DATA_WIDTH-1:0]        fmt;
    logic                         fin;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            eligible[k] = (state_q == S_RUN) && data_valid[k] && (cnt_q[k] < len_q);
        end
    end

    // Search starts just past the last granted channel, wrapping at NUM_CH.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_c   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = CH_W'(idx);
            if (!gnt_vld && eligible[idx_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_c;
            end
        end
        gnt = '0;
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    assign res_sel   = data_in[gnt_idx*RESULT_WIDTH +: RESULT_WIDTH];
    assign addr_sum  = (ADDR_WIDTH+1)'(base_q[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH]) + cnt_q[gnt_idx];
    assign addr_wrap = ADDR_WIDTH'(addr_sum % MEM_SZ);

    if (RESULT_WIDTH <= DATA_WIDTH) begin : g_sext
        assign fmt = DATA_WIDTH'($signed(res_sel));
    end else if (SATURATE == 0) begin : g_trunc
        logic unused_hi;
        assign unused_hi = ^res_sel[RESULT_WIDTH-1:DATA_WIDTH];
        assign fmt = res_sel[DATA_WIDTH-1:0];
    end else begin : g_sat
        // Value fits when all bits from the target sign bit upward agree.
        logic [RESULT_WIDTH-DATA_WIDTH:0] top;
        assign top = res_sel[RESULT_WIDTH-1:DATA_WIDTH-1];
        always_comb begin
            if (top == '0 || top == '1) fmt = res_sel[DATA_WIDTH-1:0];
            else if (res_sel[RESULT_WIDTH-1]) fmt = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else fmt = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        dat_d    = dat_q;
        ch_d     = ch_q;
        fin      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_writing) begin
                    base_d = ch_base;
                    len_d  = burst_len;
                    for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
                    state_d = (burst_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (gnt_vld) begin
                    we_d     = 1'b1;
                    addr_d   = addr_wrap;
                    dat_d    = fmt;
                    ch_d     = gnt_idx;
                    rr_ptr_d = gnt_idx;
                    cnt_d[gnt_idx] = cnt_q[gnt_idx] + 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (cnt_d[k] != len_q) fin = 1'b0;
                    end
                    if (fin) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            rr_ptr_q <= LAST_CH;
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
            ch_q     <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            ch_q     <= ch_d;
        end
    end

    assign data_ready    = gnt;
    assign write_en      = we_q;
    assign write_address = addr_q;
    assign data_out      = dat_q;
    assign write_ch      = ch_q;
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_burst_writer.sv
// Bench for mem_burst_writer: reference model checked every cycle, plus literal write-order and saturation checks.
module tb_mem_burst_writer;
    localparam int NCH = 2;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int MSZ = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start_writing;
    logic [NCH*AW-1:0] ch_base;
    logic [AW:0]     burst_len;
    logic [NCH*DW-1:0] data_in;
    logic [NCH-1:0]  data_valid;
    logic [NCH-1:0]  data_ready;
    logic            write_en;
    logic [AW-1:0]   write_address;
    logic [DW-1:0]   data_out;
    logic [0:0]      write_ch;
    logic            busy;
    logic            done;

    logic            s_start;
    logic [AW-1:0]   s_base;
    logic [AW:0]     s_len;
    logic [39:0]     s_data;
    logic [0:0]      s_valid;
    logic [0:0]      unused_sat_rdy, unused_tr_rdy, unused_sat_ch, unused_tr_ch;
    logic            unused_sat_busy, unused_tr_busy, unused_sat_done, unused_tr_done;
    logic            sat_we, tr_we;
    logic [AW-1:0]   sat_addr, unused_tr_addr;
    logic [DW-1:0]   sat_dat, tr_dat;

    always #5 clk = ~clk;

    mem_burst_writer u_dut (
        .clk(clk), .rst_n(rst_n), .start_writing(start_writing), .ch_base(ch_base),
        .burst_len(burst_len), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .write_en(write_en), .write_address(write_address), .data_out(data_out),
        .write_ch(write_ch), .busy(busy), .done(done)
    );

    mem_burst_writer #(.RESULT_WIDTH(40), .NUM_CH(1), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start_writing(s_start), .ch_base(s_base),
        .burst_len(s_len), .data_in(s_data), .data_valid(s_valid), .data_ready(unused_sat_rdy),
        .write_en(sat_we), .write_address(sat_addr), .data_out(sat_dat),
        .write_ch(unused_sat_ch), .busy(unused_sat_busy), .done(unused_sat_done)
    );

    mem_burst_writer #(.RESULT_WIDTH(40), .NUM_CH(1), .SATURATE(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .start_writing(s_start), .ch_base(s_base),
        .burst_len(s_len), .data_in(s_data), .data_valid(s_valid), .data_ready(unused_tr_rdy),
        .write_en(tr_we), .write_address(unused_tr_addr), .data_out(tr_dat),
        .write_ch(unused_tr_ch), .busy(unused_tr_busy), .done(unused_tr_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 done; expected registered write in m_we/m_addr/m_dat/m_ch.
    int          m_ph = 0;
    int          m_ptr = NCH - 1;
    int          m_len = 0;
    int          m_base [NCH];
    int          m_cnt [NCH];
    bit          m_we = 0;
    int          m_addr = 0;
    int          m_ch = 0;
    logic [31:0] m_dat = '0;

    int          q_addr[$];
    int          q_ch[$];
    int          wr_at_done = -1;
    int          we_at_done = -1;
    int          n_done = 0;
    logic [31:0] sq[$];
    logic [31:0] tq[$];
    int          sa[$];

    always @(negedge clk) begin
        int g;
        logic [NCH-1:0] er;
        bit fin;
        if (!rst_n) begin
            m_ph = 0; m_ptr = NCH - 1; m_len = 0; m_we = 0;
            for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_base[k] = 0; end
            chk("reset write_address", write_address, 0);
            chk("reset data_out", data_out, 0);
            chk("reset write_ch", write_ch, 0);
        end
        g = -1;
        er = '0;
        if (m_ph == 1) begin
            for (int i = 1; i <= NCH; i++) begin
                int k;
                k = (m_ptr + i) % NCH;
                if (g < 0 && data_valid[k] && m_cnt[k] < m_len) g = k;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("data_ready", data_ready, er);
        chk("write_en", write_en, m_we);
        if (m_we) begin
            chk("write_address", write_address, m_addr);
            chk("data_out", data_out, m_dat);
            chk("write_ch", write_ch, m_ch);
        end
        chk("busy", busy, m_ph == 1);
        chk("done", done, m_ph == 2);
        if (write_en) begin q_addr.push_back(int'(write_address)); q_ch.push_back(int'(write_ch)); end
        if (done) begin n_done++; wr_at_done = q_addr.size(); we_at_done = int'(write_en); end
        if (sat_we) begin sq.push_back(sat_dat); sa.push_back(int'(sat_addr)); end
        if (tr_we) tq.push_back(tr_dat);

        if (rst_n) begin
            m_we = 0;
            case (m_ph)
                0: if (start_writing) begin
                    for (int k = 0; k < NCH; k++) begin
                        m_base[k] = int'(ch_base[k*AW +: AW]);
                        m_cnt[k] = 0;
                    end
                    m_len = int'(burst_len);
                    m_ph = (m_len == 0) ? 2 : 1;
                end
                1: if (g >= 0) begin
                    m_we = 1;
                    m_addr = (m_base[g] + m_cnt[g]) % MSZ;
                    m_dat = data_in[g*DW +: DW];
                    m_ch = g;
                    m_cnt[g]++;
                    m_ptr = g;
                    fin = 1;
                    for (int k = 0; k < NCH; k++) if (m_cnt[k] != m_len) fin = 0;
                    if (fin) m_ph = 2;
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int b0, input int b1, input int len);
        ch_base = {AW'(b1), AW'(b0)};
        burst_len = (AW+1)'(len);
        start_writing = 1'b1;
        tick();
        start_writing = 1'b0;
    endtask

    // mode 0: both valid; 1: ch1 valid from cycle 8; 2: ch1 valid every 3rd cycle;
    // 4: both valid with a stray start in cycle 1; other: random valids and stray starts.
    task automatic run(input int mode, input int budget);
        bit seen;
        seen = 0;
        for (int c = 0; c < budget; c++) begin
            data_in = {$urandom, $urandom};
            case (mode)
                0: data_valid = 2'b11;
                1: data_valid = (c < 8) ? 2'b01 : 2'b11;
                2: data_valid = {(c % 3 == 0), 1'b1};
                4: begin
                    data_valid = 2'b11;
                    start_writing = (c == 1);
                    if (c == 1) begin ch_base = (NCH*AW)'($urandom); burst_len = 6'd7; end
                end
                default: begin
                    data_valid = 2'($urandom);
                    start_writing = ($urandom_range(7) == 0);
                    burst_len = 6'($urandom_range(8));
                    ch_base = (NCH*AW)'($urandom);
                end
            endcase
            @(negedge clk);
            if (done) begin seen = 1; break; end
            @(posedge clk);
            #1;
        end
        tick();
        start_writing = 1'b0;
        data_valid = '0;
        chk("burst completes within budget", seen, 1);
    endtask

    task automatic check_seq(input string name, input int s0, input int exp[$], input bit use_ch);
        int n;
        n = q_addr.size() - s0;
        chk({name, " write count"}, n, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < n) chk(name, use_ch ? q_ch[s0+i] : q_addr[s0+i], exp[i]);
        end
    endtask

    initial begin
        int s0;
        int nd0;
        int nwe;
        start_writing = 0; ch_base = '0; burst_len = '0; data_in = '0; data_valid = '0;
        s_start = 0; s_base = '0; s_len = '0; s_data = '0; s_valid = '0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            start_writing = i[0];
            data_valid = 2'(i);
            data_in = {$urandom, $urandom};
            burst_len = 6'd3;
        end
        @(negedge clk);
        chk("reset write_en literal", write_en, 0);
        chk("reset data_ready literal", data_ready, 0);
        tick();
        rst_n = 1'b1; start_writing = 0; data_valid = '0;
        tick();

        // Start with no valid data: busy, nothing written.
        s0 = q_addr.size();
        start_burst(0, 16, 4);
        @(negedge clk);
        chk("busy after start", busy, 1);
        chk("no write without valid", write_en, 0);
        tick();
        run(0, 40);
        check_seq("interleave addr", s0, '{0, 16, 1, 17, 2, 18, 3, 19}, 0);
        check_seq("interleave ch", s0, '{0, 1, 0, 1, 0, 1, 0, 1}, 1);
        chk("done with 8th write", wr_at_done, s0 + 8);
        chk("write_en at done", we_at_done, 1);

        // Wrap-around on ch0, ch1 arrives late.
        s0 = q_addr.size(); nd0 = n_done;
        start_burst(30, 5, 4);
        run(1, 40);
        check_seq("wrap addr", s0, '{30, 31, 0, 1, 5, 6, 7, 8}, 0);
        chk("single done for wrap burst", n_done - nd0, 1);

        // ch1 valid every third cycle.
        s0 = q_addr.size();
        start_burst(10, 20, 6);
        run(2, 60);
        check_seq("backpressure ch", s0, '{0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1}, 1);

        // Zero-length burst.
        s0 = q_addr.size();
        start_burst(3, 4, 0);
        @(negedge clk);
        chk("len0 done next cycle", done, 1);
        chk("len0 no write", write_en, 0);
        tick();
        chk("len0 write count", q_addr.size() - s0, 0);

        // Stray start during RUN is ignored.
        s0 = q_addr.size();
        start_burst(2, 9, 3);
        run(4, 40);
        check_seq("start in run addr", s0, '{2, 9, 3, 10, 4, 11}, 0);

        // Reset after the third write, then a fresh burst restarts at the bases.
        start_burst(4, 12, 5);
        data_valid = 2'b11;
        nwe = 0;
        for (int c = 0; c < 20 && nwe < 3; c++) begin
            @(negedge clk);
            if (write_en) nwe++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid-burst reset write_en", write_en, 0);
        chk("mid-burst reset busy", busy, 0);
        tick();
        rst_n = 1'b1; data_valid = '0;
        tick();
        s0 = q_addr.size();
        start_burst(4, 12, 2);
        run(0, 40);
        check_seq("restart addr", s0, '{4, 12, 5, 13}, 0);

        for (int b = 0; b < 25; b++) begin
            start_burst(int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(8)));
            run(3, 200);
        end

        // Saturation vs truncation of 40-bit results into 32-bit words.
        s_base = 5'd3; s_len = 6'd3; s_start = 1'b1;
        tick();
        s_start = 1'b0; s_valid = 1'b1; s_data = 40'h00_8000_0000;
        tick();
        s_data = 40'hFE_0000_0000;
        tick();
        s_data = 40'h00_0000_0005;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("sat write count", sq.size(), 3);
        chk("trunc write count", tq.size(), 3);
        if (sq.size() == 3) begin
            chk("sat +2^31 clamps", sq[0], 32'h7FFF_FFFF);
            chk("sat -2^33 clamps", sq[1], 32'h8000_0000);
            chk("sat 5 passes", sq[2], 32'h0000_0005);
            chk("sat addr first", sa[0], 3);
            chk("sat addr last", sa[2], 5);
        end
        if (tq.size() == 3) begin
            chk("trunc +2^31 low bits", tq[0], 32'h8000_0000);
            chk("trunc -2^33 low bits", tq[1], 32'h0000_0000);
            chk("trunc 5 passes", tq[2], 32'h0000_0005);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
